// File: rtl/phase_addr_gen.sv
// phase_addr_gen: phase accumulator address generator for a two-channel
// lookup-table oscillator. The increment (frequency) word is double-buffered
// so that a new frequency only takes effect at a period boundary.
module phase_addr_gen #(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    ACC_WIDTH     = 16,
    parameter logic [ACC_WIDTH-1:0]  INCR_RESET    = ACC_WIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic                     incr_wr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     wrap,
    output logic                     incr_pending,
    output logic                     dout_valid
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] incr_active;
    logic [ACC_WIDTH-1:0] incr_next;
    logic                 pending;
    logic                 wrap_q;
    logic                 en_q;
    logic                 dout_valid_q;

    // One extra bit on the sum exposes the carry-out of the accumulator.
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 boundary;

    assign sum   = {1'b0, acc} + {1'b0, incr_active};
    assign carry = sum[ACC_WIDTH];

    // A period boundary is the overflowing advance; a zero increment never
    // reaches one, so it is treated as permanently at a boundary.
    assign boundary = (en && carry) || (incr_active == '0);

    assign addr1        = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign addr2        = addr1 + offset;
    assign wrap         = wrap_q;
    assign incr_pending = pending;
    assign dout_valid   = dout_valid_q;

    // Advance the phase accumulator and flag the overflow for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            acc    <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= en && carry;
            if (en) begin
                acc <= sum[ACC_WIDTH-1:0];
            end
        end
    end

    // Capture new increments and swap them in only at a period boundary;
    // the accumulator above still uses the old increment on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            incr_active <= INCR_RESET;
            incr_next   <= '0;
            pending     <= 1'b0;
        end else if (incr_wr && boundary) begin
            incr_active <= incr;
            pending     <= 1'b0;
        end else if (incr_wr) begin
            incr_next   <= incr;
            pending     <= 1'b1;
        end else if (pending && boundary) begin
            incr_active <= incr_next;
            pending     <= 1'b0;
        end
    end

    // Match the accumulator stage plus the downstream table-read stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            en_q         <= en;
            dout_valid_q <= en_q;
        end
    end

endmodule

// File: tb/tb_phase_addr_gen.sv
// tb_phase_addr_gen: directed scenarios plus randomized traffic for
// phase_addr_gen, checked every cycle against a behavioural model.
module tb_phase_addr_gen;

    localparam int AW    = 8;
    localparam int CW    = 16;
    localparam int SHIFT = CW - AW;
    localparam longint unsigned ACC_MOD = 64'd1 << CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          incr_wr = 1'b0;
    logic [CW-1:0] incr = '0;
    logic [AW-1:0] offset = '0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic          wrap;
    logic          incr_pending;
    logic          dout_valid;

    int checks = 0;
    int failures = 0;

    phase_addr_gen #(
        .ADDRESS_WIDTH (AW),
        .ACC_WIDTH     (CW),
        .INCR_RESET    (16'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .incr         (incr),
        .incr_wr      (incr_wr),
        .offset       (offset),
        .addr1        (addr1),
        .addr2        (addr2),
        .wrap         (wrap),
        .incr_pending (incr_pending),
        .dout_valid   (dout_valid)
    );

    always #5 clk = ~clk;

    // Abstract oscillator state: phase, the frequency in use, a queued
    // frequency, and the en history that dout_valid must echo.
    typedef struct {
        longint unsigned phase;
        longint unsigned freq;
        longint unsigned queued;
        bit              has_queued;
        bit              wrapped;
        bit              en_1ago;
        bit              en_2ago;
    } model_t;

    model_t m;
    bit     m_valid = 1'b0;

    function automatic model_t step(model_t s, bit r, bit e, bit w, longint unsigned inc);
        model_t n;
        longint unsigned total;
        bit              overflow;
        bit              at_boundary;
        n = s;
        if (r) begin
            n.phase = 0; n.freq = 1; n.queued = 0; n.has_queued = 0;
            n.wrapped = 0; n.en_1ago = 0; n.en_2ago = 0;
            return n;
        end
        total       = s.phase + s.freq;
        overflow    = e && (total >= ACC_MOD);
        at_boundary = overflow || (s.freq == 0);
        n.wrapped   = overflow;
        if (e) n.phase = total % ACC_MOD;
        if (w && at_boundary) begin
            n.freq = inc; n.has_queued = 0;
        end else if (w) begin
            n.queued = inc; n.has_queued = 1;
        end else if (s.has_queued && at_boundary) begin
            n.freq = s.queued; n.has_queued = 0;
        end
        n.en_2ago = s.en_1ago;
        n.en_1ago = e;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on every rising edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        m <= step(m, rst, en, incr_wr, longint'(incr));
        if (rst) m_valid <= 1'b1;
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("addr1", 64'(addr1), m.phase >> SHIFT);
            check("addr2", 64'(addr2), ((m.phase >> SHIFT) + 64'(offset)) % (64'd1 << AW));
            check("wrap", 64'(wrap), 64'(m.wrapped));
            check("incr_pending", 64'(incr_pending), 64'(m.has_queued));
            check("dout_valid", 64'(dout_valid), 64'(m.en_2ago));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrap(input int limit, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrap && n < limit);
        check(name, 64'(wrap), 64'd1);
    endtask

    int nw;

    initial begin
        // Reset, then check the post-reset outputs.
        rst = 1'b1; en = 1'b0; offset = 8'h33;
        tick(); tick();
        rst = 1'b0;
        check("rst_addr1", 64'(addr1), 64'h00);
        check("rst_addr2", 64'(addr2), 64'h33);
        check("rst_pending", 64'(incr_pending), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);

        // Reset increment of 1: addr1 stays 0 for 256 advances, then reads 1.
        en = 1'b1; nw = 0;
        repeat (256) begin
            tick();
            if (wrap) nw++;
        end
        check("slow_addr1", 64'(addr1), 64'h01);
        check("slow_wraps", 64'(nw), 64'd0);

        // Queue 0x0100; it only takes effect at the next overflow.
        incr = 16'h0100; incr_wr = 1'b1;
        tick();
        incr_wr = 1'b0;
        check("q100_pending", 64'(incr_pending), 64'd1);
        wait_wrap(70000, "q100_wrap_seen");
        check("q100_apply_addr1", 64'(addr1), 64'h00);
        check("q100_apply_pending", 64'(incr_pending), 64'd0);
        nw = 0;
        repeat (256) begin
            tick();
            if (wrap) nw++;
        end
        check("q100_lap_addr1", 64'(addr1), 64'h00);
        check("q100_lap_wraps", 64'(nw), 64'd1);

        // Step 4 active, acc=0x1000, queue step 8: step stays 4 until the wrap.
        incr = 16'h0400; incr_wr = 1'b1;
        tick();
        incr_wr = 1'b0;
        wait_wrap(300, "q400_wrap_seen");
        repeat (4) tick();
        check("s4_addr1", 64'(addr1), 64'h10);
        incr = 16'h0800; incr_wr = 1'b1;
        tick();
        incr_wr = 1'b0;
        check("s4_wr_addr1", 64'(addr1), 64'h14);
        check("s4_wr_pending", 64'(incr_pending), 64'd1);
        tick();
        check("s4_still4", 64'(addr1), 64'h18);
        wait_wrap(100, "q800_wrap_seen");
        check("s8_apply_addr1", 64'(addr1), 64'h00);
        check("s8_apply_pending", 64'(incr_pending), 64'd0);
        offset = 8'd64;
        tick();
        check("s8_addr1", 64'(addr1), 64'h08);

        // Offset 64 sweep, including addr1=200 -> addr2=8.
        repeat (24) tick();
        check("off_addr1", 64'(addr1), 64'd200);
        check("off_addr2", 64'(addr2), 64'd8);
        repeat (40) tick();
        check("off_end_addr1", 64'(addr1), 64'd8);

        // en 1,0,1 -> dout_valid 1,0,1 two edges later; acc holds while en=0.
        en = 1'b0;
        repeat (3) tick();
        check("tog_idle_valid", 64'(dout_valid), 64'd0);
        check("tog_idle_addr1", 64'(addr1), 64'd8);
        en = 1'b1; tick();
        en = 1'b0; tick();
        check("tog_valid_1", 64'(dout_valid), 64'd1);
        check("tog_hold_addr1", 64'(addr1), 64'd16);
        en = 1'b1; tick();
        check("tog_valid_0", 64'(dout_valid), 64'd0);
        en = 1'b0; tick();
        check("tog_valid_1b", 64'(dout_valid), 64'd1);
        check("tog_end_addr1", 64'(addr1), 64'd24);

        // Reset mid-sweep with a queued increment discards it.
        en = 1'b1; incr = 16'h1234; incr_wr = 1'b1;
        tick();
        incr_wr = 1'b0;
        check("mid_pending", 64'(incr_pending), 64'd1);
        tick();
        rst = 1'b1; incr_wr = 1'b1; incr = 16'h5555;
        tick();
        rst = 1'b0; incr_wr = 1'b0;
        check("mid_rst_addr1", 64'(addr1), 64'd0);
        check("mid_rst_pending", 64'(incr_pending), 64'd0);
        check("mid_rst_wrap", 64'(wrap), 64'd0);
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        repeat (256) tick();
        check("mid_rst_step", 64'(addr1), 64'd1);

        // Randomized traffic, including zero increments and occasional resets.
        repeat (3000) begin
            en      = ($urandom_range(0, 3) != 0);
            incr_wr = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       incr = '0;
                1:       incr = CW'($urandom_range(0, 65535));
                default: incr = CW'(16'h0100 << $urandom_range(0, 6));
            endcase
            rst    = ($urandom_range(0, 499) == 0);
            offset = AW'($urandom_range(0, 255));
            tick();
        end
        rst = 1'b0; en = 1'b0; incr_wr = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_addr_gen.md
PHASE_ADDR_GEN -- requirements
Module: phase_addr_gen

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: width of the lookup-table address outputs.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: phase accumulator width; must be greater than or equal to ADDRESS_WIDTH.
REQ-003 SHALL have parameter INCR_RESET, default 1: active increment value loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: advance the accumulator this cycle.
REQ-007 SHALL have port incr, input, ACC_WIDTH bits: new frequency (increment) word.
REQ-008 SHALL have port incr_wr, input, 1 bit: single-cycle strobe capturing incr.
REQ-009 SHALL have port offset, input, ADDRESS_WIDTH bits: phase offset for channel 2.
REQ-010 SHALL have port addr1, output, ADDRESS_WIDTH bits: channel-1 table address.
REQ-011 SHALL have port addr2, output, ADDRESS_WIDTH bits: channel-2 table address.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse on accumulator overflow.
REQ-013 SHALL have port incr_pending, output, 1 bit: a captured increment is awaiting application.
REQ-014 SHALL have port dout_valid, output, 1 bit: downstream one-cycle-latency table output reflects a freshly advanced address.

Function
REQ-015 SHALL hold registers acc (ACC_WIDTH), incr_active (ACC_WIDTH), incr_next (ACC_WIDTH), pending, wrap, en_q and dout_valid.
REQ-016 SHALL, on each edge with en=1, update acc to (acc + incr_active) mod 2^ACC_WIDTH; with en=0, acc SHALL hold.
REQ-017 SHALL drive addr1 = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH] directly from the register, with no combinational path from en or incr.
REQ-018 SHALL drive addr2 = (addr1 + offset) mod 2^ADDRESS_WIDTH combinationally; offset is not registered.
REQ-019 SHALL drive wrap to 1 for exactly one cycle after any edge where en=1 and the accumulator carry-out was 1; otherwise wrap SHALL be 0.
REQ-020 SHALL, on incr_wr=1, capture incr into incr_next and set pending=1.
REQ-021 SHALL apply a pending increment (incr_active <= incr_next, pending <= 0) only on an edge where en=1 and the carry-out is 1, or on any edge where incr_active == 0, so the frequency never changes mid-period.
REQ-022 SHALL, when incr_wr=1 coincides with an apply edge, load the incoming incr directly into incr_active and leave pending=0.
REQ-023 SHALL, when incr_wr=1 while pending=1 and no apply occurs, overwrite incr_next and keep pending=1.
REQ-024 SHALL drive incr_pending from the pending register.
REQ-025 SHALL compute the accumulation on the apply edge with the old incr_active; the new value takes effect from the following edge.
REQ-026 SHALL pipeline en_q <= en and dout_valid <= en_q, giving a two-cycle en-to-valid latency (one accumulator stage plus one table-read stage).
REQ-027 SHALL treat incr=0 as legal: acc holds while en=1, and wrap stays 0.

Reset
REQ-028 SHALL, on an edge with rst=1, set acc=0, incr_active=INCR_RESET, incr_next=0, pending=0, wrap=0, en_q=0 and dout_valid=0, overriding en and incr_wr.
REQ-029 SHALL discard any pending increment captured before a mid-operation reset.
REQ-030 SHALL, in the cycle after reset, output addr1=0 and addr2=offset.

Verification
REQ-031 SHALL cover: reset, then en=1 for 256 cycles with INCR_RESET=1 -> addr1 stays 0 for 256 cycles, then reads 1; wrap is 0 throughout.
REQ-032 SHALL cover: incr=0x0100 applied, en=1 -> addr1 steps 0,1,2,...,255,0; wrap pulses once as addr1 returns to 0.
REQ-033 SHALL cover: incr=0x0400 active with acc=0x1000, incr_wr with incr=0x0800 -> incr_pending=1 and step stays 4 until wrap; after wrap addr1 steps by 8 and incr_pending=0.
REQ-034 SHALL cover: offset=64 with addr1 sweeping -> addr2 = (addr1+64) mod 256 every cycle, including addr1=200 -> addr2=8.
REQ-035 SHALL cover: en toggling 1,0,1 -> dout_valid toggles 1,0,1 delayed by exactly two cycles, and acc holds while en=0.
REQ-036 SHALL cover: rst asserted mid-sweep with pending=1 -> next cycle addr1=0, incr_pending=0, wrap=0, dout_valid=0, and step returns to INCR_RESET.
